// File: rtl/simd_sequencer.sv
// simd_sequencer
//
// Instruction sequencer for the SIMD processor. Owns the program counter,
// fetches one instruction word at a time from the instruction BRAM, holds it
// stable at the decoder for the datapath latency of its opcode and then
// issues a single write-back strobe. Runs from a start pulse until a HALT
// opcode or until the PC would wrap past the top of instruction memory.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        begin execution at start_addr (only looked at in IDLE)
//   start_addr   first instruction address
//   busy         high in every state except IDLE
//   done         one-cycle pulse when execution ends
//   overflow     sticky: PC would have wrapped without a HALT; cleared on start
//   ins_addr     instruction BRAM read address (the PC)
//   ins_rd_en    instruction BRAM read enable (FETCH only)
//   ins_rdata    instruction BRAM data, valid one cycle after ins_rd_en
//   instruction  registered instruction word to the decoder
//   instr_valid  instruction is live (every EXEC cycle)
//   wb_en        one-cycle write-back qualifier in the last EXEC cycle
//
// There is no valid/ready handshake here: the BRAM read is fixed-latency and
// the datapath is trusted to produce its result exactly L cycles after the
// first instr_valid cycle. Every output is decoded from registered state, so
// nothing combinational runs from start or ins_rdata to an output.
module simd_sequencer #(
  parameter int ADDR_WIDTH     = 10,
  parameter int OPCODE_WIDTH   = 3,
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_WIDTH      = OPCODE_WIDTH + 3 * ADDR_WIDTH + 1,
  parameter int PE_LATENCY     = 2,
  parameter int DOT_LATENCY    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [INS_ADDR_WIDTH-1:0] ins_addr,
  output logic                      ins_rd_en,
  input  logic [INS_WIDTH-1:0]      ins_rdata,
  output logic [INS_WIDTH-1:0]      instruction,
  output logic                      instr_valid,
  output logic                      wb_en
);

  localparam int MAX_LAT = (DOT_LATENCY > PE_LATENCY) ? DOT_LATENCY : PE_LATENCY;
  // The counter holds L-1 at most, so clog2(MAX_LAT) bits suffice.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_DOT  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP5 = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP6 = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(7);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [INS_ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [INS_WIDTH-1:0]      instr_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      ovf_nxt;
  logic [OPCODE_WIDTH-1:0]   ld_op;
  logic [OPCODE_WIDTH-1:0]   ex_op;

  function automatic logic is_nop(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_NOP5) || (op == OP_NOP6);
  endfunction

  // Latency minus one, loaded into the counter on the way into EXEC.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [OPCODE_WIDTH-1:0] op);
    if (op == OP_DOT)  return CNT_W'(DOT_LATENCY - 1);
    if (is_nop(op))    return '0;
    return CNT_W'(PE_LATENCY - 1);
  endfunction

  assign ld_op = ins_rdata[INS_WIDTH-1 -: OPCODE_WIDTH];
  assign ex_op = instruction[INS_WIDTH-1 -: OPCODE_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      instruction <= '0;
      cnt         <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instruction <= instr_nxt;
      cnt         <= cnt_nxt;
      overflow    <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instruction;
    cnt_nxt   = cnt;
    ovf_nxt   = overflow;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = start_addr;
          ovf_nxt   = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        // HALT still lands in the instruction register but never goes live.
        instr_nxt = ins_rdata;
        if (ld_op == OP_HALT) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = lat_m1(ld_op);
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (pc == '1) begin
          // Running off the end of instruction memory ends the program
          // instead of wrapping to address 0.
          ovf_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          pc_nxt    = pc + INS_ADDR_WIDTH'(1);
          state_nxt = S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign ins_rd_en   = (state == S_FETCH);
  assign ins_addr    = pc;
  assign instr_valid = (state == S_EXEC);
  assign wb_en       = (state == S_EXEC) && (cnt == '0) && !is_nop(ex_op);

endmodule
